// File: rtl/rv32_debug_pkg.sv
// Shared encodings for the RV32 debug memory master: host opcodes, port select
// values and the master's FSM state type.
package rv32_debug_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_HOLD    = 2'b10,
    OP_RELEASE = 2'b11
  } op_e;

  localparam logic SEL_INST = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_RESP
  } state_e;

endpackage

// File: rtl/rv32_debug_mem_master.sv
// Host-side initiator for the core's debug InstRAM/DataRAM ports, with
// single-word writes, burst reads and ownership of the core reset hold.
module rv32_debug_mem_master
  import rv32_debug_pkg::*;
#(
  parameter int unsigned RD_LATENCY    = 1,
  parameter int unsigned LEN_W         = 8,
  parameter bit          HOLD_ON_RESET = 1'b1
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_sel,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [3:0]       cmd_be,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_last,
  output logic [31:0]      inst_a2,
  output logic [31:0]      inst_wd2,
  output logic [3:0]       inst_we2,
  input  logic [31:0]      inst_rd2,
  output logic [31:0]      data_a2,
  output logic [31:0]      data_wd2,
  output logic [3:0]       data_we2,
  input  logic [31:0]      data_rd2,
  output logic             cpu_hold
);

  localparam int unsigned LAT_W = 2;

  state_e           r_state;
  logic             r_sel;
  logic [31:0]      r_addr;
  logic [LEN_W-1:0] r_rem;
  logic [LAT_W-1:0] r_lat;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic             r_rsp_last;
  logic [31:0]      r_rsp_data;
  logic [31:0]      r_a2;
  logic [31:0]      r_wd2;
  logic [3:0]       r_we2;
  logic             r_hold;

  op_e         w_op;
  logic [31:0] w_addr_al;
  logic [31:0] w_addr_nxt;
  logic        w_accept;
  logic        w_unused;

  assign w_op       = op_e'(cmd_op);
  assign w_addr_al  = {cmd_addr[31:2], 2'b00};
  assign w_addr_nxt = r_addr + 32'd4;
  assign w_accept   = cmd_valid && r_cmd_ready;
  assign w_unused   = ^cmd_addr[1:0];

  // a2/wd2/we2 are registered one edge ahead so they appear in the WR /
  // RD_ISSUE cycle itself, not one cycle later.
  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      r_state     <= ST_IDLE;
      r_sel       <= SEL_INST;
      r_addr      <= '0;
      r_rem       <= '0;
      r_lat       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_data  <= '0;
      r_a2        <= '0;
      r_wd2       <= '0;
      r_we2       <= '0;
      r_hold      <= HOLD_ON_RESET;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_sel  <= cmd_sel;
            r_addr <= w_addr_al;
            r_rem  <= cmd_len;
            case (w_op)
              OP_WRITE: begin
                r_cmd_ready <= 1'b0;
                r_a2        <= w_addr_al;
                r_wd2       <= cmd_wdata;
                r_we2       <= cmd_be;
                r_state     <= ST_WR;
              end
              OP_READ: begin
                r_cmd_ready <= 1'b0;
                r_a2        <= w_addr_al;
                r_wd2       <= '0;
                r_we2       <= '0;
                r_state     <= ST_RD_ISSUE;
              end
              OP_HOLD:    r_hold <= 1'b1;
              OP_RELEASE: r_hold <= 1'b0;
              default:    r_hold <= r_hold;
            endcase
          end
        end
        ST_WR: begin
          r_a2        <= '0;
          r_wd2       <= '0;
          r_we2       <= '0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        ST_RD_ISSUE: begin
          r_a2    <= r_addr;
          r_we2   <= '0;
          r_lat   <= LAT_W'(RD_LATENCY - 1);
          r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (r_lat == '0) begin
            r_rsp_data  <= (r_sel == SEL_DATA) ? data_rd2 : inst_rd2;
            r_rsp_last  <= (r_rem == '0);
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RD_RESP;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        ST_RD_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            if (r_rem == '0) begin
              r_a2        <= '0;
              r_cmd_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_addr  <= w_addr_nxt;
              r_a2    <= w_addr_nxt;
              r_rem   <= r_rem - 1'b1;
              r_state <= ST_RD_ISSUE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    inst_a2  = '0;
    inst_wd2 = '0;
    inst_we2 = '0;
    data_a2  = '0;
    data_wd2 = '0;
    data_we2 = '0;
    if (r_sel == SEL_DATA) begin
      data_a2  = r_a2;
      data_wd2 = r_wd2;
      data_we2 = r_we2;
    end else begin
      inst_a2  = r_a2;
      inst_wd2 = r_wd2;
      inst_we2 = r_we2;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;
  assign cpu_hold  = r_hold;

endmodule

// File: tb/tb_rv32_debug_mem_master.sv
// Self-checking bench for rv32_debug_mem_master: BRAM models on both debug
// ports, a word-level reference memory, directed cases and random traffic.
module tb_rv32_debug_mem_master;
  import rv32_debug_pkg::*;

  localparam int unsigned RD_LAT = 1;
  localparam int unsigned LW     = 8;

  logic          CPU_CLK = 1'b0;
  logic          CPU_RST_N = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic          cmd_sel = 1'b0;
  logic [31:0]   cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_be = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_data;
  logic          rsp_last;
  logic [31:0]   inst_a2, inst_wd2, data_a2, data_wd2;
  logic [3:0]    inst_we2, data_we2;
  logic [31:0]   inst_rd2 = '0;
  logic [31:0]   data_rd2 = '0;
  logic          cpu_hold;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        m_hold  = 1'b1;

  logic [31:0] bram_i [logic [31:0]];
  logic [31:0] bram_d [logic [31:0]];
  logic [31:0] ref_i  [logic [31:0]];
  logic [31:0] ref_d  [logic [31:0]];

  rv32_debug_mem_master #(
    .RD_LATENCY   (RD_LAT),
    .LEN_W        (LW),
    .HOLD_ON_RESET(1'b1)
  ) dut (
    .CPU_CLK  (CPU_CLK),
    .CPU_RST_N(CPU_RST_N),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_sel  (cmd_sel),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_be   (cmd_be),
    .cmd_len  (cmd_len),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_last (rsp_last),
    .inst_a2  (inst_a2),
    .inst_wd2 (inst_wd2),
    .inst_we2 (inst_we2),
    .inst_rd2 (inst_rd2),
    .data_a2  (data_a2),
    .data_wd2 (data_wd2),
    .data_we2 (data_we2),
    .data_rd2 (data_rd2),
    .cpu_hold (cpu_hold)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  // Synchronous single-cycle-latency BRAMs, read-before-write.
  always @(posedge CPU_CLK) begin
    inst_rd2 <= bram_i.exists(inst_a2) ? bram_i[inst_a2] : 32'h0;
    data_rd2 <= bram_d.exists(data_a2) ? bram_d[data_a2] : 32'h0;
    if (inst_we2 != 4'h0)
      bram_i[inst_a2] = merge(bram_i.exists(inst_a2) ? bram_i[inst_a2] : 32'h0, inst_wd2, inst_we2);
    if (data_we2 != 4'h0)
      bram_d[data_a2] = merge(bram_d.exists(data_a2) ? bram_d[data_a2] : 32'h0, data_wd2, data_we2);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic s, input logic [31:0] a);
    if (s) return ref_d.exists(a) ? ref_d[a] : 32'h0;
    return ref_i.exists(a) ? ref_i[a] : 32'h0;
  endfunction

  function automatic logic [31:0] port_a2(input logic s);
    return s ? data_a2 : inst_a2;
  endfunction

  function automatic logic [31:0] other_a2(input logic s);
    return s ? inst_a2 : data_a2;
  endfunction

  task automatic tick();
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic s, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input logic [LW-1:0] len);
    int unsigned n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = s;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_be    = be;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic s, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
    logic [31:0] ea;
    ea = {a[31:2], 2'b00};
    send_cmd(OP_WRITE, s, a, wd, be, '0);
    check("wr_a2", port_a2(s), ea);
    check("wr_wd2", s ? data_wd2 : inst_wd2, wd);
    check("wr_we2", s ? data_we2 : inst_we2, be);
    check("wr_other", {other_a2(s), s ? inst_we2 : data_we2}, 0);
    check("wr_busy", cmd_ready, 0);
    if (s) ref_d[ea] = merge(ref_rd(1'b1, ea), wd, be);
    else   ref_i[ea] = merge(ref_rd(1'b0, ea), wd, be);
    tick();
    check("wr_we2_off", {inst_we2, data_we2}, 0);
    check("wr_ready_back", cmd_ready, 1);
  endtask

  task automatic do_read(input logic s, input logic [31:0] a, input int unsigned len,
                         input bit rnd, input logic [7:0] pat);
    logic [31:0] ea;
    logic [31:0] exp_d;
    int unsigned cyc;
    int unsigned st;
    ea = {a[31:2], 2'b00};
    send_cmd(OP_READ, s, a, '0, '0, LW'(len));
    for (int unsigned k = 0; k <= len; k++) begin
      exp_d = ref_rd(s, ea);
      check("rd_a2", port_a2(s), ea);
      check("rd_other_we", {other_a2(s), inst_we2, data_we2}, 0);
      cyc = 0;
      while (!rsp_valid && cyc < 40) begin
        tick();
        cyc++;
      end
      check("rd_latency", cyc, RD_LAT + 1);
      st = rnd ? $urandom_range(0, 2) : int'(pat[2*k +: 2]);
      for (int unsigned j = 0; j < st; j++) begin
        check("rd_stall_valid", rsp_valid, 1);
        check("rd_stall_data", rsp_data, exp_d);
        tick();
      end
      check("rd_data", rsp_data, exp_d);
      check("rd_last", rsp_last, (k == len));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rd_valid_drop", rsp_valid, 0);
      ea = ea + 32'd4;
    end
    check("rd_done_ready", cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [31:0] a;
    int unsigned op;
    repeat (3) @(posedge CPU_CLK);
    #1;
    check("rst_ready", cmd_ready, 0);
    check("rst_rsp", {rsp_valid, rsp_last, rsp_data}, 0);
    check("rst_inst", {inst_a2, inst_wd2, inst_we2}, 0);
    check("rst_data", {data_a2, data_wd2, data_we2}, 0);
    check("rst_hold", cpu_hold, 1);
    CPU_RST_N = 1'b1;
    tick();
    check("rst_ready_up", cmd_ready, 1);

    do_write(1'b0, 32'h0000_0013, 32'hDEAD_BEEF, 4'hF);
    do_read(1'b0, 32'h0000_0010, 0, 1'b0, 8'h00);

    do_write(1'b1, 32'h0000_0008, 32'h1234_BEEF, 4'h3);
    check("be_merge_ref", ref_rd(1'b1, 32'h8), 32'h0000_BEEF);
    do_read(1'b1, 32'h0000_0008, 0, 1'b0, 8'h00);

    do_write(1'b1, 32'hFFFF_FFF8, 32'hA0A0_0001, 4'hF);
    do_write(1'b1, 32'hFFFF_FFFC, 32'hA0A0_0002, 4'hF);
    do_write(1'b1, 32'h0000_0000, 32'hA0A0_0003, 4'hF);
    do_write(1'b1, 32'h0000_0004, 32'hA0A0_0004, 4'hF);
    do_write(1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'h0);
    do_read(1'b1, 32'hFFFF_FFF8, 3, 1'b0, 8'b00_00_10_00);

    send_cmd(OP_HOLD, 1'b0, '0, '0, '0, '0);
    check("hold_set", cpu_hold, 1);
    check("hold_ready", cmd_ready, 1);
    send_cmd(OP_RELEASE, 1'b0, '0, '0, '0, '0);
    check("release", cpu_hold, 0);
    check("hold_no_rsp", rsp_valid, 0);
    m_hold = 1'b0;

    rsp_ready = 1'b0;
    send_cmd(OP_READ, 1'b1, 32'h0000_0000, '0, '0, LW'(3));
    tick();
    CPU_RST_N = 1'b0;
    tick();
    check("abort_valid", rsp_valid, 0);
    check("abort_ready", cmd_ready, 0);
    check("abort_hold", cpu_hold, 1);
    check("abort_a2", {inst_a2, data_a2}, 0);
    m_hold = 1'b1;
    tick();
    CPU_RST_N = 1'b1;
    tick();
    check("abort_idle", cmd_ready, 1);
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    check("abort_no_stale", seen, 0);

    do_read(1'b0, 32'h0000_0100, (1 << LW) - 1, 1'b1, 8'h00);

    for (int i = 0; i < 60; i++) begin
      a  = ($urandom_range(0, 1) ? 32'hFFFF_FFE0 : 32'h0) + (32'($urandom_range(0, 15)) << 2)
           + 32'($urandom_range(0, 3));
      op = $urandom_range(0, 9);
      if (op < 5) begin
        do_write(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end else if (op < 8) begin
        do_read(1'($urandom_range(0, 1)), a, $urandom_range(0, 3), 1'b1, 8'h00);
      end else begin
        m_hold = (op == 8);
        send_cmd(m_hold ? OP_HOLD : OP_RELEASE, 1'b0, a, '0, '0, '0);
        check("rnd_hold", cpu_hold, m_hold);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_debug_mem_master.md
Name: rv32_debug_mem_master

Overview:
- Initiator for the core's debug memory ports: drives the InstRAM/DataRAM A2/WD2/WE2 inputs and samples RD2.
- Lets the host or test loader preload programs, patch data and dump memory over a valid/ready command/response interface.
- Also owns the core reset hold (cpu_hold), so a program can be loaded before the core runs.
- Sits between the board-level host link and the RV32 core top.

Parameters:
- RD_LATENCY, 1, cycles from A2 presented to RD2 valid (synchronous BRAM); legal range 1..3.
- LEN_W, 8, width of burst length field; max burst = 2^LEN_W words.
- HOLD_ON_RESET, 1, reset value of cpu_hold.

Ports:
- CPU_CLK  in  1  clock
- CPU_RST_N  in  1  synchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_op  in  2  00 WRITE, 01 READ, 10 HOLD, 11 RELEASE
- cmd_sel  in  1  0 InstRAM, 1 DataRAM
- cmd_addr  in  32  byte address; [1:0] ignored
- cmd_wdata  in  32  write data
- cmd_be  in  4  write byte enables
- cmd_len  in  LEN_W  READ burst length minus 1
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_data  out  32  read word
- rsp_last  out  1  final word of burst
- inst_a2 / inst_wd2  out  32 / 32  to CPU_Debug_InstRAM_A2/WD2
- inst_we2  out  4  to CPU_Debug_InstRAM_WE2
- inst_rd2  in  32  from CPU_Debug_InstRAM_RD2
- data_a2 / data_wd2  out  32 / 32  to CPU_Debug_DataRAM_A2/WD2
- data_we2  out  4  to CPU_Debug_DataRAM_WE2
- data_rd2  in  32  from CPU_Debug_DataRAM_RD2
- cpu_hold  out  1  drives core CPU_RST (1 = core held in reset)

Behaviour:
- Clock and reset: one clock, CPU_CLK. Reset is synchronous and active-low (CPU_RST_N).
- Reset values:
  - State IDLE.
  - cmd_ready, rsp_valid, rsp_last = 0.
  - rsp_data, all a2/wd2 = 0; we2 = 0.
  - cpu_hold = HOLD_ON_RESET.
- Reset mid-burst aborts the burst: pending responses are discarded and no write is issued.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE:
  - cmd_ready = 1 (first cycle after reset release onward).
  - On accept, latch sel, addr&~3, wdata, be, len.
  - WRITE -> WR. READ -> RD_ISSUE.
  - HOLD / RELEASE: cpu_hold <= 1 / 0 on the accepting edge; stay in IDLE; no response.
- WR (1 cycle):
  - Selected port gets a2 = addr, wd2 = wdata, we2 = be; then -> IDLE.
  - be = 0: cycle still consumed, no bytes written.
  - A write accepted at edge T appears on we2 during cycle T+1 only.
- RD_ISSUE:
  - Drive a2 = current addr, we2 = 0; latency counter <= RD_LATENCY-1; -> RD_WAIT.
- RD_WAIT:
  - a2 held.
  - When counter = 0, capture selected rd2 into rsp_data; rsp_last = (remaining == 0); -> RD_RESP.
  - Otherwise decrement the counter.
  - With RD_LATENCY = 1: accept at T, a2 driven in T+1, rd2 sampled at end of T+2, rsp_valid high from T+3.
- RD_RESP:
  - rsp_valid = 1; rsp_data and rsp_last stable until rsp_ready.
  - On handshake, if remaining == 0 -> IDLE (cmd_ready rises the next cycle).
  - Otherwise addr += 4 (mod 2^32, wraps 0xFFFFFFFC -> 0x0), remaining -= 1, -> RD_ISSUE.
- cmd_ready = 0 in every state except IDLE.
- Back-to-back burst throughput with rsp_ready = 1: one word per RD_LATENCY+2 cycles.
- Non-selected port: a2 = 0, wd2 = 0, we2 = 0. we2 on both ports is 0 outside WR.
- cmd_len = 2^LEN_W-1 reads 2^LEN_W words; the remaining counter must not underflow.
- Memory access is legal regardless of cpu_hold; the host is responsible for coherence.
- The core's own port is independent; no arbitration is performed.

Decomposition:
- Package rv32_debug_pkg: op encodings (OP_WRITE, OP_READ, OP_HOLD, OP_RELEASE), SEL_INST/SEL_DATA, FSM state enum.
- No sub-module; a single module of about 200 lines. Port muxing is combinational on the latched sel.

Test Plan:
- Reset with HOLD_ON_RESET = 1: all outputs 0 except cpu_hold = 1; cmd_ready = 1 on the first post-reset cycle.
- WRITE sel = 0, addr 0x00000013, wdata 0xDEADBEEF, be 0xF: exactly one cycle with inst_a2 = 0x10, inst_wd2 = 0xDEADBEEF, inst_we2 = 0xF; data_we2 stays 0.
- WRITE sel = 1, addr 0x8, be 0x3, then READ len 0 from a BRAM model: rsp_data = 0x0000BEEF (over a prior 0), rsp_last = 1, rsp_valid at accept+3.
- READ sel = 1, addr 0xFFFFFFF8, len 3, with rsp_ready toggling 1,0,0,1: data_a2 sequence FFFFFFF8, FFFFFFFC, 0, 4; rsp_data held while stalled; rsp_last only on the 4th word.
- HOLD then RELEASE back-to-back: cpu_hold 1 -> 0 one edge after the second accept; no rsp_valid.
- Reset asserted during RD_WAIT of a 4-word burst: rsp_valid stays 0, state returns to IDLE, and no stale response appears after release.
